// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block: alignment modes, count direction
// and the default counter width.
package pwm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 24;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up counter (edge-aligned) or up/down counter (center-aligned)
// with period-boundary detection.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             boundary
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] top;

  assign top = period - WIDTH'(1);

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (period == '0) begin
      // Idle: counter parked, every cycle is a boundary.
      cnt_d    = '0;
      dir_d    = DIR_UP;
      boundary = 1'b1;
    end else if (mode == MODE_EDGE || period == WIDTH'(1)) begin
      dir_d = DIR_UP;
      if (cnt_q == top) begin
        cnt_d    = '0;
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else if (dir_q == DIR_UP) begin
      // The top value is held once more on the way down.
      if (cnt_q == top) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      if (cnt_q == '0) begin
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt = cnt_q;
  assign dir = dir_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase, double-buffered period/compare/mode
// applied at period boundaries, registered glitch-free outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned         WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned         CHANNELS = 4,
  parameter logic [CHANNELS-1:0] POLARITY = {CHANNELS{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] compare_in,
  input  logic                      mode_in,
  input  logic                      load,
  input  logic [CHANNELS-1:0]       enable,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_done,
  output logic                      load_done
);

  logic [WIDTH-1:0]                 period_act_q, period_act_d;
  logic [WIDTH-1:0]                 period_pend_q, period_pend_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   cmp_act_q, cmp_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   cmp_pend_q, cmp_pend_d;
  logic                             mode_act_q, mode_act_d;
  logic                             mode_pend_q, mode_pend_d;
  logic                             pend_valid_q, pend_valid_d;
  logic [CHANNELS-1:0]              pwm_q, pwm_d;
  logic                             period_done_q, load_done_q;

  logic [WIDTH-1:0]                 cnt;
  logic                             dir;
  logic                             boundary;
  logic                             apply;
  logic [CHANNELS-1:0]              pwm_raw;
  logic                             unused_dir;

  pwm_timebase #(
    .WIDTH (WIDTH)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .period   (period_act_q),
    .mode     (mode_act_q),
    .cnt      (cnt),
    .dir      (dir),
    .boundary (boundary)
  );

  assign unused_dir = dir;

  // Apply uses the pending values as they stood before this cycle's load.
  assign apply = boundary & pend_valid_q;

  always_comb begin
    period_pend_d = period_pend_q;
    cmp_pend_d    = cmp_pend_q;
    mode_pend_d   = mode_pend_q;
    pend_valid_d  = pend_valid_q;
    period_act_d  = period_act_q;
    cmp_act_d     = cmp_act_q;
    mode_act_d    = mode_act_q;
    if (apply) begin
      period_act_d = period_pend_q;
      cmp_act_d    = cmp_pend_q;
      mode_act_d   = mode_pend_q;
      pend_valid_d = 1'b0;
    end
    if (load) begin
      period_pend_d = period_in;
      cmp_pend_d    = compare_in;
      mode_pend_d   = mode_in;
      pend_valid_d  = 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign pwm_raw[i] = enable[i] & (period_act_q != '0) & (cnt < cmp_act_q[i]);
  end

  assign pwm_d = pwm_raw ^ POLARITY;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_act_q  <= '0;
      period_pend_q <= '0;
      cmp_act_q     <= '0;
      cmp_pend_q    <= '0;
      mode_act_q    <= MODE_EDGE;
      mode_pend_q   <= MODE_EDGE;
      pend_valid_q  <= 1'b0;
      pwm_q         <= POLARITY;
      period_done_q <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      period_act_q  <= period_act_d;
      period_pend_q <= period_pend_d;
      cmp_act_q     <= cmp_act_d;
      cmp_pend_q    <= cmp_pend_d;
      mode_act_q    <= mode_act_d;
      mode_pend_q   <= mode_pend_d;
      pend_valid_q  <= pend_valid_d;
      pwm_q         <= pwm_d;
      period_done_q <= boundary;
      load_done_q   <= apply;
    end
  end

  assign pwm         = pwm_q;
  assign period_done = period_done_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (4 channels, pwm[2] inverted).
module tb_pwm_multi;

  localparam int unsigned W = 24;
  localparam int unsigned N = 4;
  localparam logic [N-1:0] POL = 4'b0100;

  logic           clk;
  logic           rst;
  logic [W-1:0]   period_in;
  logic [N*W-1:0] compare_in;
  logic           mode_in;
  logic           load;
  logic [N-1:0]   enable;
  logic [N-1:0]   pwm;
  logic           period_done;
  logic           load_done;

  int checks;
  int failures;

  pwm_multi #(
    .WIDTH    (W),
    .CHANNELS (N),
    .POLARITY (POL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .period_in   (period_in),
    .compare_in  (compare_in),
    .mode_in     (mode_in),
    .load        (load),
    .enable      (enable),
    .pwm         (pwm),
    .period_done (period_done),
    .load_done   (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] p, input logic [W-1:0] c0, input logic [W-1:0] c1,
                         input logic [W-1:0] c2, input logic [W-1:0] c3, input logic m);
    period_in  = p;
    compare_in = {c3, c2, c1, c0};
    mode_in    = m;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic wait_load(input int budget);
    int n;
    n = 0;
    while (!load_done && n < budget) begin
      step();
      n++;
    end
    check_eq("load_done_seen", {31'd0, load_done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_pwm;
    logic         hi;
    int           c;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    period_in = '0;
    compare_in = '0;
    mode_in = 1'b0;
    load = 1'b0;
    enable = 4'b1111;

    // Reset state and idle (P=0) behaviour.
    step();
    step();
    check_eq("rst_pwm", {28'd0, pwm}, {28'd0, POL});
    check_eq("rst_pdone", {31'd0, period_done}, 32'd0);
    check_eq("rst_ldone", {31'd0, load_done}, 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("idle_pwm", {28'd0, pwm}, {28'd0, POL});
      check_eq("idle_pdone", {31'd0, period_done}, 32'd1);
    end

    // Edge mode P=256, C0=192.
    enable = 4'b0001;
    do_load(24'd256, 24'd192, 24'd0, 24'd0, 24'd0, 1'b0);
    wait_load(10);
    for (int k = 1; k <= 512; k++) begin
      step();
      hi = ((k - 1) % 256) < 192;
      exp_pwm = {1'b0, 1'b1, 1'b0, hi};
      check_eq("edge_pwm", {28'd0, pwm}, {28'd0, exp_pwm});
      check_eq("edge_pdone", {31'd0, period_done}, {31'd0, (k % 256) == 0});
    end

    // Center mode P=8, C1=2.
    enable = 4'b0010;
    do_load(24'd8, 24'd0, 24'd2, 24'd0, 24'd0, 1'b1);
    wait_load(600);
    for (int k = 1; k <= 32; k++) begin
      step();
      hi = (((k - 1) % 16) < 2) || (((k - 1) % 16) >= 14);
      exp_pwm = {1'b0, 1'b1, hi, 1'b0};
      check_eq("ctr_pwm", {28'd0, pwm}, {28'd0, exp_pwm});
      check_eq("ctr_pdone", {31'd0, period_done}, {31'd0, (k % 16) == 0});
    end

    // Shadowing: mid-period load, then two loads in one period (last wins).
    enable = 4'b0001;
    do_load(24'd100, 24'd30, 24'd0, 24'd0, 24'd0, 1'b0);
    wait_load(100);
    for (int k = 1; k <= 400; k++) begin
      load = (k == 11) || (k == 211) || (k == 241);
      if (k == 11) compare_in = {72'd0, 24'd70};
      if (k == 211) compare_in = {72'd0, 24'd50};
      if (k == 241) compare_in = {72'd0, 24'd60};
      step();
      load = 1'b0;
      c = (k <= 100) ? 30 : ((k <= 300) ? 70 : 60);
      hi = ((k - 1) % 100) < c;
      exp_pwm = {1'b0, 1'b1, 1'b0, hi};
      check_eq("shadow_pwm", {28'd0, pwm}, {28'd0, exp_pwm});
      check_eq("shadow_ldone", {31'd0, load_done}, {31'd0, (k == 100) || (k == 300)});
    end

    // Boundary compares with P=16, then enable[0] dropped mid-period.
    enable = 4'b1111;
    do_load(24'd16, 24'd16, 24'd0, 24'd1000, 24'd8, 1'b0);
    wait_load(300);
    for (int k = 1; k <= 48; k++) begin
      if (k == 40) enable = 4'b1110;
      step();
      hi = ((k - 1) % 16) < 8;
      exp_pwm = {hi, 1'b0, 1'b0, k < 40};
      check_eq("bound_pwm", {28'd0, pwm}, {28'd0, exp_pwm});
    end

    // P=1, C=1 in center mode behaves as edge P=1: constant high, boundary every cycle.
    enable = 4'b0001;
    do_load(24'd1, 24'd1, 24'd0, 24'd0, 24'd0, 1'b1);
    wait_load(40);
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq("p1_pwm", {28'd0, pwm}, 32'h5);
      check_eq("p1_pdone", {31'd0, period_done}, 32'd1);
    end

    // Load on the boundary cycle waits for the following boundary.
    do_load(24'd10, 24'd5, 24'd0, 24'd0, 24'd0, 1'b0);
    wait_load(10);
    for (int k = 1; k <= 30; k++) begin
      load = (k == 10);
      if (k == 10) compare_in = {72'd0, 24'd3};
      step();
      load = 1'b0;
      c = (k <= 20) ? 5 : 3;
      hi = ((k - 1) % 10) < c;
      check_eq("lob_pwm", {28'd0, pwm}, {28'd0, 1'b0, 1'b1, 1'b0, hi});
      check_eq("lob_ldone", {31'd0, load_done}, {31'd0, k == 20});
      check_eq("lob_pdone", {31'd0, period_done}, {31'd0, (k % 10) == 0});
    end

    // Back to idle, then load from P=0 applies one cycle after the load cycle.
    do_load(24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 1'b0);
    wait_load(20);
    enable = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_eq("p0_pwm", {28'd0, pwm}, {28'd0, POL});
      check_eq("p0_pdone", {31'd0, period_done}, 32'd1);
    end
    enable = 4'b0001;
    period_in = 24'd10;
    compare_in = {72'd0, 24'd5};
    load = 1'b1;
    step();
    load = 1'b0;
    check_eq("p0load_ldone0", {31'd0, load_done}, 32'd0);
    step();
    check_eq("p0load_ldone1", {31'd0, load_done}, 32'd1);
    step();
    check_eq("p0load_pwm", {28'd0, pwm}, 32'h5);

    // Asynchronous reset mid-period.
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    check_eq("midrst_pwm", {28'd0, pwm}, {28'd0, POL});
    check_eq("midrst_pdone", {31'd0, period_done}, 32'd0);
    check_eq("midrst_ldone", {31'd0, load_done}, 32'd0);
    step();
    rst = 1'b1;
    enable = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("postrst_pwm", {28'd0, pwm}, {28'd0, POL});
      check_eq("postrst_ldone", {31'd0, load_done}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
